// File: rtl/alu_sequencer.sv
// Issue stage for the 4-bit ALU: accepts one instruction per 3 cycles,
// drives registered operands to the ALU and writes the result back.
module alu_sequencer #(
  parameter int DATA_W   = 4,
  parameter int RF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [15:0]         instr,
  output logic [3:0]          alu_op,
  output logic [DATA_W-1:0]   alu_x,
  output logic [DATA_W-1:0]   alu_y,
  output logic                alu_cin,
  input  logic [2*DATA_W-1:0] alu_result,
  input  logic                alu_cout,
  output logic                done,
  output logic                flag_z,
  output logic                flag_c,
  output logic                flag_err,
  input  logic [1:0]          dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_MULT = 4'b1010;
  localparam logic [3:0] OP_LDI  = 4'b1111;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [1:0]          rd_q, rd_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_x_q, alu_x_d, alu_y_q, alu_y_d;
  logic                alu_cin_q, alu_cin_d;
  logic                flag_z_q, flag_z_d, flag_c_q, flag_c_d, flag_err_q, flag_err_d;
  logic [DATA_W-1:0]   rf_q [RF_DEPTH];
  logic [DATA_W-1:0]   rf_d [RF_DEPTH];
  logic                accept;
  logic [1:0]          rd_hi;
  logic                unused_rsv;

  assign unused_rsv = instr[4];

  // State register and all datapath/flag flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_op_q   <= '0;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      alu_cin_q  <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_err_q <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      alu_op_q   <= alu_op_d;
      alu_x_q    <= alu_x_d;
      alu_y_q    <= alu_y_d;
      alu_cin_q  <= alu_cin_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
      flag_err_q <= flag_err_d;
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= rf_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == IDLE);
    done        = (state_q == DONE);
  end

  assign accept = instr_valid & instr_ready;

  // Operands are read at the accept edge so they are stable through EXEC
  always_comb begin
    op_d      = op_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    alu_op_d  = alu_op_q;
    alu_x_d   = alu_x_q;
    alu_y_d   = alu_y_q;
    alu_cin_d = alu_cin_q;
    if (accept) begin
      op_d      = instr[15:12];
      rd_d      = instr[11:10];
      imm_d     = instr[3:0];
      alu_op_d  = instr[15:12];
      alu_x_d   = rf_q[instr[9:8]];
      alu_y_d   = rf_q[instr[7:6]];
      alu_cin_d = instr[5];
    end
  end

  assign rd_hi = rd_q + 2'd1;

  // Writeback and flag update on the closing edge of EXEC
  always_comb begin
    for (int i = 0; i < RF_DEPTH; i++) rf_d[i] = rf_q[i];
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    flag_err_d = flag_err_q;
    if (state_q == EXEC) begin
      flag_err_d = 1'b0;
      case (op_q)
        4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110: begin
          rf_d[rd_q] = alu_result[DATA_W-1:0];
          flag_z_d   = (alu_result[DATA_W-1:0] == '0);
        end
        OP_ADD, OP_SUB: begin
          rf_d[rd_q] = alu_result[DATA_W-1:0];
          flag_z_d   = (alu_result[DATA_W-1:0] == '0);
          flag_c_d   = alu_cout;
        end
        OP_MULT: begin
          rf_d[rd_q]  = alu_result[DATA_W-1:0];
          rf_d[rd_hi] = alu_result[2*DATA_W-1:DATA_W];
          flag_z_d    = (alu_result == '0);
        end
        OP_LDI: begin
          rf_d[rd_q] = imm_q;
          flag_z_d   = (imm_q == '0);
        end
        default: flag_err_d = 1'b1;
      endcase
    end
  end

  assign alu_op   = alu_op_q;
  assign alu_x    = alu_x_q;
  assign alu_y    = alu_y_q;
  assign alu_cin  = alu_cin_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;
  assign flag_err = flag_err_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; the bench plays the ALU and supplies
// hand-computed results for each instruction.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  alu_op, alu_x, alu_y;
  logic        alu_cin;
  logic [7:0]  alu_result;
  logic        alu_cout;
  logic        done, flag_z, flag_c, flag_err;
  logic [1:0]  dbg_addr;
  logic [3:0]  dbg_data;

  int vectors    = 0;
  int miscompares = 0;

  logic [3:0] ex_op, ex_x, ex_y;
  logic       ex_cin, ex_done, ex_ready, d_done, d_err, d_ready, post_done;
  logic [3:0] rv;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .done(done), .flag_z(flag_z),
    .flag_c(flag_c), .flag_err(flag_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [1:0] rt,
                                     input logic cin, input logic [3:0] imm);
    return {op, rd, rs, rt, cin, 1'b0, imm};
  endfunction

  task automatic rd_reg(input logic [1:0] a, output logic [3:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Full 3-cycle transaction with snapshots of EXEC, DONE and following IDLE
  task automatic do_instr(input logic [15:0] ins, input logic [7:0] res, input logic cout);
    @(negedge clk);
    instr = ins; instr_valid = 1'b1; alu_result = res; alu_cout = cout;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    ex_op = alu_op; ex_x = alu_x; ex_y = alu_y; ex_cin = alu_cin;
    ex_done = done; ex_ready = instr_ready;
    @(posedge clk); #1;
    d_done = done; d_err = flag_err; d_ready = instr_ready;
    @(posedge clk); #1;
    post_done = done;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; alu_result = '0; alu_cout = 1'b0;
    dbg_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Put something nonzero in R3 and the flags, then reset mid-cycle
    do_instr(mk(4'hF, 2'd3, 2'd0, 2'd0, 1'b0, 4'h5), 8'h00, 1'b0);
    do_instr(mk(4'h8, 2'd1, 2'd3, 2'd3, 1'b0, 4'h0), 8'h1A, 1'b1);
    chk("pre_reset_c", flag_c, 1'b1);
    @(negedge clk); #2 reset = 1'b1; #1;
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_flags", {flag_z, flag_c, flag_err}, 3'b000);
    chk("rst_alu", {alu_op, alu_x, alu_y, 3'b000, alu_cin}, 16'h0);
    for (int a = 0; a < 4; a++) begin
      rd_reg(a[1:0], rv);
      chk($sformatf("rst_R%0d", a), rv, 4'h0);
    end
    @(negedge clk); reset = 1'b0;

    // LDI R0=1101, LDI R1=1110 (ALU result ignored), AND R2=R0&R1
    do_instr(mk(4'hF, 2'd0, 2'd0, 2'd0, 1'b0, 4'hD), 8'hFF, 1'b1);
    chk("ldi_op", ex_op, 4'hF);
    rd_reg(2'd0, rv); chk("ldi_R0", rv, 4'hD);
    chk("ldi_c_held", flag_c, 1'b0);
    do_instr(mk(4'hF, 2'd1, 2'd0, 2'd0, 1'b0, 4'hE), 8'h00, 1'b0);
    rd_reg(2'd1, rv); chk("ldi_R1", rv, 4'hE);
    chk("ldi_z", flag_z, 1'b0);
    do_instr(mk(4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0), 8'h0C, 1'b0);
    chk("and_op", ex_op, 4'h0);
    chk("and_x", ex_x, 4'hD);
    chk("and_y", ex_y, 4'hE);
    chk("and_exec_done", ex_done, 1'b0);
    chk("and_exec_ready", ex_ready, 1'b0);
    chk("and_done", d_done, 1'b1);
    chk("and_done_ready", d_ready, 1'b0);
    chk("and_done_1cyc", post_done, 1'b0);
    chk("and_err", d_err, 1'b0);
    rd_reg(2'd2, rv); chk("and_R2", rv, 4'hC);
    chk("and_z", flag_z, 1'b0);
    chk("alu_hold_idle", alu_x, 4'hD);

    // ADD R3 = 13 + 14 + 1 = 28 -> 1100, carry out
    do_instr(mk(4'h8, 2'd3, 2'd0, 2'd1, 1'b1, 4'h0), 8'h0C, 1'b1);
    chk("add_op", ex_op, 4'h8);
    chk("add_cin", ex_cin, 1'b1);
    rd_reg(2'd3, rv); chk("add_R3", rv, 4'hC);
    chk("add_c", flag_c, 1'b1);
    chk("add_z", flag_z, 1'b0);
    do_instr(mk(4'h0, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0), 8'h0C, 1'b0);
    chk("and_keeps_c", flag_c, 1'b1);
    // XOR R2 = R0 ^ R0 = 0 -> zero flag, carry still held
    do_instr(mk(4'h4, 2'd2, 2'd0, 2'd0, 1'b0, 4'h0), 8'h00, 1'b0);
    chk("xor_y", ex_y, 4'hD);
    rd_reg(2'd2, rv); chk("xor_R2", rv, 4'h0);
    chk("xor_z", flag_z, 1'b1);
    chk("xor_c", flag_c, 1'b1);

    // MULT rd=3: 13*14 = 182 = 1011_0110, high nibble wraps into R0
    do_instr(mk(4'hA, 2'd3, 2'd0, 2'd1, 1'b0, 4'h0), 8'hB6, 1'b0);
    chk("mul_x", ex_x, 4'hD);
    chk("mul_y", ex_y, 4'hE);
    rd_reg(2'd3, rv); chk("mul_R3", rv, 4'h6);
    rd_reg(2'd0, rv); chk("mul_R0", rv, 4'hB);
    rd_reg(2'd1, rv); chk("mul_R1", rv, 4'hE);
    chk("mul_z", flag_z, 1'b0);
    chk("mul_c", flag_c, 1'b1);

    // Illegal op 0111 with valid held high; next instruction waits for IDLE
    @(negedge clk);
    instr = mk(4'h7, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0); instr_valid = 1'b1;
    alu_result = 8'h55; alu_cout = 1'b0;
    @(posedge clk); #1;
    chk("ill_exec_ready", instr_ready, 1'b0);
    instr = mk(4'hF, 2'd1, 2'd0, 2'd0, 1'b0, 4'h7);
    @(posedge clk); #1;
    chk("ill_done", done, 1'b1);
    chk("ill_err", flag_err, 1'b1);
    chk("ill_done_ready", instr_ready, 1'b0);
    @(posedge clk); #1;
    chk("ill_idle_done", done, 1'b0);
    chk("ill_idle_ready", instr_ready, 1'b1);
    chk("ill_flags", {flag_z, flag_c}, 2'b01);
    rd_reg(2'd2, rv); chk("ill_R2", rv, 4'h0);
    rd_reg(2'd1, rv); chk("ill_R1_pending", rv, 4'hE);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("bp_accept_ready", instr_ready, 1'b0);
    chk("bp_accept_op", alu_op, 4'hF);
    @(posedge clk); #1;
    chk("bp_done", done, 1'b1);
    chk("bp_err_clear", flag_err, 1'b0);
    rd_reg(2'd1, rv); chk("bp_R1", rv, 4'h7);
    @(posedge clk); #1;

    // Reset during EXEC of ADD R2 aborts the instruction
    @(negedge clk);
    instr = mk(4'h8, 2'd2, 2'd0, 2'd1, 1'b0, 4'h0); instr_valid = 1'b1;
    alu_result = 8'h02; alu_cout = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    #2 reset = 1'b1; #1;
    chk("abort_ready", instr_ready, 1'b1);
    chk("abort_done", done, 1'b0);
    @(posedge clk); #1;
    chk("abort_no_done", done, 1'b0);
    rd_reg(2'd2, rv); chk("abort_R2", rv, 4'h0);
    chk("abort_c", flag_c, 1'b0);
    @(negedge clk); reset = 1'b0;
    do_instr(mk(4'hF, 2'd2, 2'd0, 2'd0, 1'b0, 4'h1), 8'h00, 1'b0);
    chk("post_rst_done", d_done, 1'b1);
    rd_reg(2'd2, rv); chk("post_rst_R2", rv, 4'h1);
    chk("post_rst_z", flag_z, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Upstream issue stage for the 4-bit ALU datapath. It accepts instruction words over a valid/ready handshake and reads operands from a 4x4-bit register file. It drives op/x/y/cin to the ALU, then writes the ALU result back and updates the zero, carry and error flags. Throughput is one instruction per 3 cycles.

Parameters:
DATA_W, 4, operand/register width; only 4 is supported
RF_DEPTH, 4, register count; fixed at 4, with 2-bit register addresses

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  stage can accept an instruction
instr  in  16  {op[15:12], rd[11:10], rs[9:8], rt[7:6], cin[5], rsv[4], imm[3:0]}
alu_op  out  4  operation code to the ALU
alu_x  out  4  first operand, R[rs]
alu_y  out  4  second operand, R[rt]
alu_cin  out  1  carry-in
alu_result  in  8  ALU result; low nibble for non-multiply ops, full 8 bits for multiply
alu_cout  in  1  ALU carry-out
done  out  1  one-cycle pulse when an instruction retires
flag_z  out  1  zero flag
flag_c  out  1  carry flag
flag_err  out  1  illegal opcode; valid only while done=1
dbg_addr  in  2  debug read address
dbg_data  out  4  combinational read, R[dbg_addr]

Behaviour:
- Reset, asynchronous and immediate: state=IDLE; R0..R3=0; flag_z, flag_c, flag_err, done all 0; alu_op/x/y/cin=0; instr_ready=1 once state is IDLE.
- FSM states IDLE, EXEC, DONE:
  - IDLE: instr_ready=1. On instr_valid & instr_ready, latch instr and go to EXEC.
  - EXEC: instr_ready=0. alu_op=op, alu_x=R[rs], alu_y=R[rt], alu_cin=cin, all registered and stable for the full cycle. On the closing edge, perform writeback and flag update, then go to DONE.
  - DONE: done=1, instr_ready=0, then go to IDLE.
- Accept at edge N: EXEC is cycle N..N+1 and done is high in cycle N+1..N+2. The next accept is possible at edge N+3.
- alu_* outputs hold their last values in IDLE and DONE.
- Opcode map:
  - Logic ops 0000-0110 (AND, NAND, OR, NOR, XOR, XNOR, NOT): R[rd] <= alu_result[3:0]; flag_z <= (alu_result[3:0]==0); flag_c held.
  - ADD 1000 and SUB 1001: R[rd] <= alu_result[3:0]; flag_z as above; flag_c <= alu_cout.
  - MULT 1010: R[rd] <= alu_result[3:0]; R[(rd+1) mod 4] <= alu_result[7:4]; flag_z <= (alu_result==0); flag_c held. rd=3 wraps its high nibble into R0.
  - LDI 1111: R[rd] <= imm. No ALU dependence: alu_op is still driven 1111 and alu_result is ignored. flag_z <= (imm==0); flag_c held.
  - Illegal ops 0111 and 1011-1110: no register write, flags z/c held, flag_err=1 during DONE. flag_err=0 on every legal retire.
- rsv is ignored. rs==rt and rd==rs/rt are legal; operands are sampled before writeback.
- instr_valid while instr_ready=0: not accepted. The upstream must hold the instruction; the stage has no internal buffering.
- dbg_data is combinational from the register file and reflects a write from the cycle after the write edge.
- Reset during EXEC or DONE: instruction aborted, no writeback, done not pulsed, everything returns to reset values.

Test Plan:
1. Reset check: assert reset mid-simulation -> within the same cycle, instr_ready=1 (IDLE), done=0, flags=0; dbg_data=0000 for all four addresses.
2. Load and AND: LDI R0=1101, LDI R1=1110, then AND rd=2 rs=0 rt=1 -> during EXEC alu_op=0000, alu_x=1101, alu_y=1110; after done, R2=1100, flag_z=0, flag_err=0; done is exactly one cycle, 2 cycles after accept.
3. ADD with carry: ADD rd=3 rs=0 rt=1 cin=1, with ALU returning 1100 and cout=1 (13+14+1=28) -> R3=1100, flag_c=1. A following AND leaves flag_c=1.
4. MULT with wrap: MULT rd=3 rs=0 rt=1, alu_result=10110110 (13*14=182) -> R3=0110, R0=1011, R1 unchanged at 1110, flag_z=0.
5. Illegal opcode and backpressure:
   - Op 0111 issued with instr_valid held high through EXEC -> exactly one accept, flag_err=1 during done, no register change, flag_c and flag_z unchanged.
   - Next valid instruction is accepted only at the cycle after DONE.
6. Reset mid-operation: ADD R2 issued, reset asserted during EXEC -> R2 keeps its reset value 0000, no done pulse; after release, a new LDI R2=0001 executes normally.
